mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Parametrised N-port arbiter that shares one synchronous single-port RAM between the chip8 requesters (CPU, GPU, VGA, and future DMA/sound masters). It generalises the fixed three-client memory wiring to NUM_PORTS channels. All ports use one level-request/ack protocol, and the block pipelines one RAM access per cycle. It sits between the requesters and the RAM macro inside the chip8 top level.

## Interface
- NUM_PORTS, 3, number of requester ports (2..8)
- ADDR_W, 12, address width
- DATA_W, 8, data width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- port_req  in  NUM_PORTS  per-port access request, level, bit i = port i
- port_we  in  NUM_PORTS  1 = write, 0 = read
- port_addr  in  NUM_PORTS*ADDR_W  port i at [i*ADDR_W +: ADDR_W]
- port_wdata  in  NUM_PORTS*DATA_W  port i at [i*DATA_W +: DATA_W]
- port_ack  out  NUM_PORTS  one-cycle completion pulse per port
- port_rdata  out  DATA_W  read data, shared by all ports, valid only with that port's ack
- mem_en  out  1  RAM access strobe, registered
- mem_we  out  1  RAM write enable, registered
- mem_addr  out  ADDR_W  RAM address, registered
- mem_wdata  out  DATA_W  RAM write data, registered
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en

## Operation
- Eligible set = port_req & ~busy, where busy[i] is set from grant until the end of port i's ack cycle.
- Each cycle, at most one eligible port is granted. The picker selects it.
- The granted port's we, addr and wdata are registered onto mem_*. mem_en = 1 for exactly one cycle per grant.
- Reads and writes both complete with an ack. For a read, port_rdata = mem_rdata in the ack cycle.
- Requester holds req, we, addr and wdata stable until ack. These inputs are sampled only in the grant cycle.
- If req stays high after ack, it is treated as a new request.
- port_req dropped before grant: the request is abandoned and no access occurs.
- No eligible port: mem_en = 0 and no state changes except the busy clear.
- Idle ports and outputs: port_ack = 0. port_rdata = mem_rdata passthrough, undefined when no ack.

## Timing
- Cycle t: req seen, port eligible, grant.
- Cycle t+1: mem_en/we/addr/wdata driven.
- Cycle t+2: port_ack[i] = 1, and for a read port_rdata is valid.
- Fixed 2-cycle latency with no contention. Each cycle of lost arbitration adds one cycle.
- Aggregate throughput is 1 access/cycle. A single port peaks at 1 access/3 cycles, because it is busy during t+1 and t+2 and re-eligible at t+3.
- Simultaneous req on all ports from idle: grants go out on consecutive cycles and the acks are consecutive.
- Reset (rst_n = 0 at an edge) sets:
  - port_ack = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0
  - busy = 0, round-robin pointer = 0
- Reset mid-operation: in-flight accesses produce no ack. A write already presented on mem_* before the reset edge is completed by the RAM and is not rolled back.

## Configuration
- MEM_ARBITER_RR_EN defined: round-robin arbitration. After granting port g, the search starts at port (g+1) mod NUM_PORTS. The pointer updates only on a grant.
- MEM_ARBITER_RR_EN undefined: fixed priority, lowest index wins (CPU=0 over GPU=1 over VGA=2). The pointer register is not built.

## Structure
- Shared package chip8_pkg holds:
  - constants CHIP8_ADDR_W = 12 and CHIP8_DATA_W = 8
  - port index constants PORT_CPU = 0, PORT_GPU = 1, PORT_VGA = 2
  - typedef mem_cmd_t {we, addr, wdata}
- Sub-module mem_arb_picker: combinational. Inputs are the eligible vector and the start pointer. Outputs are grant_valid and a one-hot grant plus its binary index. It is reused by the GPU command queue.

## Test plan
- Single read, port 0, addr 0x200, RAM holds 0xA2: mem_en at t+1 with mem_addr = 0x200, port_ack[0] at t+2, port_rdata = 0xA2.
- Write then read, port 1, write 0x55 to 0xF00 then read 0xF00: mem_we = 1 with mem_wdata = 0x55, second ack returns 0x55.
- All three ports request from idle in the same cycle, with RR_EN defined: grant order 0,1,2, acks at t+2, t+3, t+4. A second simultaneous burst grants in the same rotating order.
- Same stimulus with RR_EN undefined and port 0 requesting continuously: port 0 granted at t, t+3, t+6. Ports 1 and 2 fill the gaps (t+1, t+2). No port starves while port 0 is busy.
- rst_n asserted in the cycle after a read grant: no ack is issued. All outputs are 0 the cycle after the reset edge. The first request after reset is served with 2-cycle latency.
- port_req[2] dropped before it is granted, while port 0 holds the bus: no mem_en with port 2's address appears and port_ack[2] never pulses.

Source files
------------

// File: rtl/chip8_pkg.sv
// chip8_pkg: constants and types shared by the chip8 memory subsystem.
//   CHIP8_ADDR_W / CHIP8_DATA_W : RAM geometry
//   PORT_CPU / PORT_GPU / PORT_VGA : fixed requester slots on mem_arbiter
//   mem_cmd_t : one RAM command (write flag, address, write data)
package chip8_pkg;

    localparam int unsigned CHIP8_ADDR_W = 12;
    localparam int unsigned CHIP8_DATA_W = 8;

    localparam int unsigned PORT_CPU = 0;
    localparam int unsigned PORT_GPU = 1;
    localparam int unsigned PORT_VGA = 2;

    typedef struct packed {
        logic                    we;
        logic [CHIP8_ADDR_W-1:0] addr;
        logic [CHIP8_DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and RAM-side signals of mem_arbiter.
//   port_req/we/addr/wdata : per-port requests (port i at slice i)
//   port_ack/rdata          : per-port completion pulse and shared read data
//   mem_en/we/addr/wdata    : registered RAM command
//   mem_rdata               : RAM read data, one cycle after mem_en
// Modports: slave = arbiter view, master = requester/RAM environment view.
interface mem_arbiter_if
    import chip8_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ADDR_W    = CHIP8_ADDR_W,
    parameter int unsigned DATA_W    = CHIP8_DATA_W
);

    logic [NUM_PORTS-1:0]        port_req;
    logic [NUM_PORTS-1:0]        port_we;
    logic [NUM_PORTS*ADDR_W-1:0] port_addr;
    logic [NUM_PORTS*DATA_W-1:0] port_wdata;
    logic [NUM_PORTS-1:0]        port_ack;
    logic [DATA_W-1:0]           port_rdata;
    logic                        mem_en;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;

    modport slave (
        input  port_req, port_we, port_addr, port_wdata, mem_rdata,
        output port_ack, port_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output port_req, port_we, port_addr, port_wdata, mem_rdata,
        input  port_ack, port_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_picker.sv
// mem_arb_picker: combinational search for the first set bit of eligible_i,
// starting at index start_i and wrapping around.
//   eligible_i    : candidate vector
//   start_i       : first index examined (must be < NUM_PORTS)
//   grant_valid_o : some candidate found
//   grant_oh_o    : one-hot winner (zero when nothing found)
//   grant_idx_o   : binary index of the winner
module mem_arb_picker #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] eligible_i,
    input  logic [IDX_W-1:0]     start_i,
    output logic                 grant_valid_o,
    output logic [NUM_PORTS-1:0] grant_oh_o,
    output logic [IDX_W-1:0]     grant_idx_o
);

    // One extra bit so start + offset cannot overflow before wrapping.
    logic [IDX_W:0] cand;

    always_comb begin
        grant_valid_o = 1'b0;
        grant_oh_o    = '0;
        grant_idx_o   = '0;
        cand          = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = {1'b0, start_i} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_PORTS)) begin
                cand = cand - (IDX_W+1)'(NUM_PORTS);
            end
            if (!grant_valid_o && eligible_i[cand[IDX_W-1:0]]) begin
                grant_valid_o                  = 1'b1;
                grant_idx_o                    = cand[IDX_W-1:0];
                grant_oh_o[cand[IDX_W-1:0]]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port RAM between NUM_PORTS
// level-request/ack requesters, one access per cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : mem_arbiter_if.slave (requester ports and RAM command)
// Timing: grant in cycle t, mem_* in t+1, port_ack (and read data) in t+2.
// Build option MEM_ARBITER_RR_EN: round-robin arbitration; when undefined,
// fixed priority with the lowest port index winning.
module mem_arbiter
    import chip8_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ADDR_W    = CHIP8_ADDR_W,
    parameter int unsigned DATA_W    = CHIP8_DATA_W
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);

    localparam int unsigned IdxW = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0] busy_q, busy_d;
    logic [NUM_PORTS-1:0] issue_q, issue_d;  // owner of the access on mem_*
    logic [NUM_PORTS-1:0] ack_q;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] grant_oh;
    logic                 grant_valid;
    logic [IdxW-1:0]      grant_idx;
    logic [IdxW-1:0]      start_ptr;

    logic                 mem_en_q, mem_en_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;

    // A port stays ineligible from its grant through its ack cycle.
    assign eligible = bus.port_req & ~busy_q;

    mem_arb_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IdxW)
    ) u_picker (
        .eligible_i    (eligible),
        .start_i       (start_ptr),
        .grant_valid_o (grant_valid),
        .grant_oh_o    (grant_oh),
        .grant_idx_o   (grant_idx)
    );

`ifdef MEM_ARBITER_RR_EN
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            rr_ptr_d = (grant_idx == IdxW'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign start_ptr = rr_ptr_q;
`else
    assign start_ptr = '0;
`endif

    always_comb begin
        // Grant and ack never hit the same port in one cycle.
        busy_d      = (busy_q & ~ack_q) | grant_oh;
        issue_d     = grant_oh;
        mem_en_d    = grant_valid;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (grant_valid) begin
            mem_we_d    = bus.port_we[grant_idx];
            mem_addr_d  = bus.port_addr[grant_idx*ADDR_W +: ADDR_W];
            mem_wdata_d = bus.port_wdata[grant_idx*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q      <= '0;
            issue_q     <= '0;
            ack_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            busy_q      <= busy_d;
            issue_q     <= issue_d;
            ack_q       <= issue_q;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.port_ack   = ack_q;
    assign bus.port_rdata = bus.mem_rdata;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random stimulus for mem_arbiter, checked
// against a transaction-level reference model (grant rules, fixed
// latencies, and a reference memory image). Honours MEM_ARBITER_RR_EN.
module tb_mem_arbiter;
    import chip8_pkg::*;

    localparam int NP = 3;
    localparam int AW = CHIP8_ADDR_W;
    localparam int DW = CHIP8_DATA_W;

    typedef struct {
        int            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            gcyc;
    } txn_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mem_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus_if ();

    mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a == 12'h200) ? 8'hA2 : (a[7:0] ^ 8'h3C);
    endfunction

    // RAM macro model: stores value ^ init_val so it starts preloaded.
    bit [DW-1:0] ram_x [1<<AW];
    always @(posedge clk) begin
        if (bus_if.mem_en === 1'b1) begin
            bus_if.mem_rdata <= ram_x[bus_if.mem_addr] ^ init_val(bus_if.mem_addr);
            if (bus_if.mem_we === 1'b1) begin
                ram_x[bus_if.mem_addr] <= bus_if.mem_wdata ^ init_val(bus_if.mem_addr);
            end
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    txn_t          inflight [$];
    int            cyc = 0;
    int            busy_until [NP];
    int            ptr = 0;
    logic          last_we;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_wdata;

    // Requesters
    bit            req_on [NP];
    bit            req_we [NP];
    bit            keep_req [NP];
    bit            granted [NP];
    logic [AW-1:0] req_addr [NP];
    logic [DW-1:0] req_wdata [NP];

    // Observations
    int            ack_cnt [NP];
    int            ack_cyc [NP];
    logic [DW-1:0] ack_rdata [NP];
    logic [AW-1:0] watch_addr = '0;
    int            hits [$];

    int checks = 0;
    int errors = 0;
    int t0;
    int n0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic int pick();
        int s;
`ifdef MEM_ARBITER_RR_EN
        s = ptr;
`else
        s = 0;
`endif
        for (int k = 0; k < NP; k++) begin
            int p;
            p = (s + k) % NP;
            if (req_on[p] && cyc >= busy_until[p]) return p;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            bus_if.port_req[p]              = req_on[p];
            bus_if.port_we[p]               = req_we[p];
            bus_if.port_addr[p*AW +: AW]    = req_addr[p];
            bus_if.port_wdata[p*DW +: DW]   = req_wdata[p];
        end
    endtask

    task automatic set_req(input int p, input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_on[p]    = 1'b1;
        req_we[p]    = we;
        req_addr[p]  = a;
        req_wdata[p] = d;
        drive();
    endtask

    task automatic check_outputs(input bit was_reset);
        bit            en_exp;
        logic [NP-1:0] ack_exp;
        bit            rd_chk;
        logic [DW-1:0] rd_exp;
        en_exp  = 1'b0;
        ack_exp = '0;
        rd_chk  = 1'b0;
        rd_exp  = '0;
        foreach (inflight[k]) begin
            if (inflight[k].gcyc == cyc - 1) begin
                en_exp     = 1'b1;
                last_we    = inflight[k].we;
                last_addr  = inflight[k].addr;
                last_wdata = inflight[k].wdata;
            end
            if (inflight[k].gcyc == cyc - 2) begin
                ack_exp[inflight[k].port] = 1'b1;
                if (!inflight[k].we) begin
                    rd_chk = 1'b1;
                    rd_exp = inflight[k].rdata;
                end
            end
        end
        check("mem_en", 32'(bus_if.mem_en), 32'(en_exp));
        if (en_exp || was_reset) begin
            check("mem_we", 32'(bus_if.mem_we), 32'(last_we));
            check("mem_addr", 32'(bus_if.mem_addr), 32'(last_addr));
            check("mem_wdata", 32'(bus_if.mem_wdata), 32'(last_wdata));
        end
        check("port_ack", 32'(bus_if.port_ack), 32'(ack_exp));
        if (rd_chk) check("port_rdata", 32'(bus_if.port_rdata), 32'(rd_exp));
        for (int p = 0; p < NP; p++) begin
            if (bus_if.port_ack[p] === 1'b1) begin
                ack_cnt[p]++;
                ack_cyc[p]   = cyc;
                ack_rdata[p] = bus_if.port_rdata;
            end
        end
        if (bus_if.mem_en === 1'b1 && bus_if.mem_addr === watch_addr) hits.push_back(cyc);
    endtask

    // Advance one clock: model the edge, then check the new cycle.
    task automatic tick();
        bit was_reset;
        int g;
        foreach (inflight[k]) begin
            if (inflight[k].gcyc == cyc - 1) begin
                inflight[k].rdata = ref_rd(inflight[k].addr);
                if (inflight[k].we) ref_mem[inflight[k].addr] = inflight[k].wdata;
            end
        end
        was_reset = (rst_n == 1'b0);
        if (was_reset) begin
            inflight.delete();
            ptr        = 0;
            last_we    = 1'b0;
            last_addr  = '0;
            last_wdata = '0;
            for (int p = 0; p < NP; p++) begin
                busy_until[p] = 0;
                granted[p]    = 1'b0;
            end
        end else begin
            while (inflight.size() > 0 && inflight[0].gcyc < cyc - 1) void'(inflight.pop_front());
            g = pick();
            if (g >= 0) begin
                txn_t t;
                t.port  = g;
                t.we    = req_we[g];
                t.addr  = req_addr[g];
                t.wdata = req_wdata[g];
                t.rdata = '0;
                t.gcyc  = cyc;
                inflight.push_back(t);
                busy_until[g] = cyc + 3;
                ptr           = (g + 1) % NP;
                granted[g]    = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check_outputs(was_reset);
        foreach (inflight[k]) begin
            if (inflight[k].gcyc == cyc - 2) begin
                granted[inflight[k].port] = 1'b0;
                if (!keep_req[inflight[k].port]) req_on[inflight[k].port] = 1'b0;
            end
        end
        drive();
    endtask

    task automatic wait_ack(input int p, input int budget);
        int start;
        int i;
        start = ack_cnt[p];
        i     = 0;
        while (ack_cnt[p] == start && i < budget) begin
            tick();
            i++;
        end
        check("wait_ack", 32'(ack_cnt[p] - start), 32'd1);
    endtask

    initial begin
        for (int p = 0; p < NP; p++) begin
            req_on[p] = 1'b0; req_we[p] = 1'b0; keep_req[p] = 1'b0; granted[p] = 1'b0;
            req_addr[p] = '0; req_wdata[p] = '0; busy_until[p] = 0;
            ack_cnt[p] = 0; ack_cyc[p] = -1; ack_rdata[p] = '0;
        end
        last_we = 1'b0; last_addr = '0; last_wdata = '0;
        drive();

        // Reset: all outputs zero
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Simultaneous burst from idle, twice
        for (int b = 0; b < 2; b++) begin
            t0 = cyc;
            for (int p = 0; p < NP; p++) set_req(p, 1'b0, 12'(12'h010 + 16 * p), '0);
            repeat (6) tick();
            for (int p = 0; p < NP; p++) check("burst_ack_cyc", 32'(ack_cyc[p] - t0), 32'(2 + p));
        end

        // Port 0 requesting continuously, ports 1 and 2 fill the gaps
        watch_addr = 12'h100;
        hits.delete();
        keep_req[PORT_CPU] = 1'b1;
        set_req(PORT_CPU, 1'b0, 12'h100, '0);
        set_req(PORT_GPU, 1'b1, 12'h101, 8'h11);
        set_req(PORT_VGA, 1'b0, 12'h102, '0);
        t0 = cyc;
        while (cyc < t0 + 7) tick();
        keep_req[PORT_CPU] = 1'b0;
        repeat (4) tick();
        check("cpu_grants", 32'(hits.size()), 32'd3);
        for (int k = 0; k < hits.size(); k++) check("cpu_en_cyc", 32'(hits[k] - t0), 32'(1 + 3 * k));
        check("gpu_ack_cyc", 32'(ack_cyc[PORT_GPU] - t0), 32'd3);
        check("vga_ack_cyc", 32'(ack_cyc[PORT_VGA] - t0), 32'd4);

        // Single read, port 0, 0x200
        watch_addr = 12'h200;
        hits.delete();
        t0 = cyc;
        set_req(PORT_CPU, 1'b0, 12'h200, '0);
        wait_ack(PORT_CPU, 8);
        check("rd_en_cnt", 32'(hits.size()), 32'd1);
        if (hits.size() > 0) check("rd_en_cyc", 32'(hits[0] - t0), 32'd1);
        check("rd_ack_lat", 32'(ack_cyc[PORT_CPU] - t0), 32'd2);
        check("rd_data", 32'(ack_rdata[PORT_CPU]), 32'h0A2);

        // Write then read back, port 1
        set_req(PORT_GPU, 1'b1, 12'hF00, 8'h55);
        wait_ack(PORT_GPU, 8);
        set_req(PORT_GPU, 1'b0, 12'hF00, '0);
        wait_ack(PORT_GPU, 8);
        check("wr_rd_data", 32'(ack_rdata[PORT_GPU]), 32'h055);
        repeat (2) tick();

        // Reset while a write sits on mem_*
        set_req(PORT_CPU, 1'b1, 12'h060, 8'h77);
        n0 = ack_cnt[PORT_CPU];
        tick();
        rst_n = 1'b0;
        for (int p = 0; p < NP; p++) req_on[p] = 1'b0;
        drive();
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("rst_no_ack", 32'(ack_cnt[PORT_CPU] - n0), 32'd0);
        t0 = cyc;
        set_req(PORT_CPU, 1'b0, 12'h060, '0);
        wait_ack(PORT_CPU, 8);
        check("post_rst_lat", 32'(ack_cyc[PORT_CPU] - t0), 32'd2);
        check("post_rst_data", 32'(ack_rdata[PORT_CPU]), 32'h077);
        repeat (2) tick();

        // Port 2 drops its request before it is granted
        watch_addr = 12'hABC;
        hits.delete();
        n0 = ack_cnt[PORT_VGA];
        set_req(PORT_CPU, 1'b0, 12'h070, '0);
        tick();
        set_req(PORT_GPU, 1'b0, 12'h071, '0);
        set_req(PORT_VGA, 1'b0, 12'hABC, '0);
        tick();
        req_on[PORT_VGA] = 1'b0;
        drive();
        repeat (6) tick();
        check("drop_no_en", 32'(hits.size()), 32'd0);
        check("drop_no_ack", 32'(ack_cnt[PORT_VGA] - n0), 32'd0);

        // Random traffic on a small address window
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NP; p++) begin
                if (!req_on[p] && $urandom_range(0, 2) == 0) begin
                    keep_req[p] = ($urandom_range(0, 3) == 0);
                    set_req(p, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)),
                            8'($urandom));
                end else if (req_on[p] && !granted[p] && $urandom_range(0, 9) == 0) begin
                    req_on[p] = 1'b0;
                end
            end
            drive();
            tick();
        end
        for (int p = 0; p < NP; p++) begin
            keep_req[p] = 1'b0;
            if (!granted[p]) req_on[p] = 1'b0;
        end
        drive();
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
